// File: rtl/inst_loader.sv
`default_nettype none
// ============================================================================
//  Module      : inst_loader
//  Description : Instruction store and playback sequencer. Instructions are
//                loaded one per load pulse and replayed in order, one per step.
//  Revision    : 1.0 - initial release
// ============================================================================
module inst_loader #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load_pulse,
    input  logic [WIDTH-1:0] inst_in,
    input  logic             step_pulse,
    input  logic             clear_pulse,
    input  logic             halt,
    output logic [WIDTH-1:0] inst_out,
    output logic             inst_valid,
    output logic [AW:0]      count,
    output logic [AW:0]      rd_ptr,
    output logic             full,
    output logic             empty,
    output logic             overflow,
    output logic             done
);

    localparam logic [AW:0] c_FULL_COUNT = DEPTH[AW:0];
    localparam logic [AW:0] c_ONE        = {{AW{1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        S_LOAD = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [WIDTH-1:0] r_inst_out;
    logic             r_inst_valid;
    logic [AW:0]      r_count;
    logic [AW:0]      r_wr_ptr;
    logic [AW:0]      r_rd_ptr;
    logic             r_overflow;

    logic             w_full;
    logic             w_empty;
    logic             w_clear;
    logic             w_wr_en;
    logic             w_set_ovf;
    logic             w_emit;
    logic [AW:0]      w_rd_idx;

    assign w_full  = (r_count == c_FULL_COUNT);
    assign w_empty = (r_count == '0);

    // A load in LOAD state wins over a simultaneous step.
    always_comb begin
        w_state_nxt = r_state;
        w_clear     = 1'b0;
        w_wr_en     = 1'b0;
        w_set_ovf   = 1'b0;
        w_emit      = 1'b0;
        w_rd_idx    = r_rd_ptr;
        if (clear_pulse) begin
            w_clear     = 1'b1;
            w_state_nxt = S_LOAD;
        end else begin
            case (r_state)
                S_LOAD: begin
                    if (load_pulse) begin
                        if (!w_full) begin
                            w_wr_en = 1'b1;
                        end else begin
                            w_set_ovf = 1'b1;
                        end
                    end else if (step_pulse && !w_empty && !halt) begin
                        w_emit      = 1'b1;
                        w_rd_idx    = '0;
                        w_state_nxt = S_RUN;
                    end
                end
                S_RUN: begin
                    if (step_pulse && !halt) begin
                        if (r_rd_ptr < r_count) begin
                            w_emit = 1'b1;
                        end else begin
                            w_state_nxt = S_DONE;
                        end
                    end
                end
                default: begin
                    w_state_nxt = r_state;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= S_LOAD;
            r_inst_out   <= '0;
            r_inst_valid <= 1'b0;
            r_count      <= '0;
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_overflow   <= 1'b0;
        end else if (w_clear) begin
            r_state      <= S_LOAD;
            r_inst_out   <= '0;
            r_inst_valid <= 1'b0;
            r_count      <= '0;
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_overflow   <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_inst_valid <= w_emit;
            if (w_emit) begin
                r_inst_out <= r_mem[w_rd_idx[AW-1:0]];
                r_rd_ptr   <= w_rd_idx + c_ONE;
            end
            if (w_wr_en) begin
                r_count  <= r_count + c_ONE;
                r_wr_ptr <= r_wr_ptr + c_ONE;
            end
            if (w_set_ovf) begin
                r_overflow <= 1'b1;
            end
        end
    end

    // Storage is not reset; the top pointer bit guards against writing past the end.
    always_ff @(posedge clk) begin
        if (w_wr_en && !r_wr_ptr[AW]) begin
            r_mem[r_wr_ptr[AW-1:0]] <= inst_in;
        end
    end

    assign inst_out   = r_inst_out;
    assign inst_valid = r_inst_valid;
    assign count      = r_count;
    assign rd_ptr     = r_rd_ptr;
    assign full       = w_full;
    assign empty      = w_empty;
    assign overflow   = r_overflow;
    assign done       = (r_state == S_DONE);

endmodule
`default_nettype wire
